pc_update_unit: RTL

- Program-counter stage that consumes the word-aligned offset produced by the left-shift-by-2 stage. Holds the PC register and computes PC+4, the branch target (PC+4 + shifted offset), the jump target and the register-jump target.
- Selects the next PC and presents a fetch request to instruction memory using a valid/ready handshake.
- Sits between the shifter/control path and the instruction memory port.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_target_mux.sv | 42 ++++
 rtl/pc_update_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared PC-stage types: FSM state encoding, next-PC select codes, reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_PC4 = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_t;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC target computation and priority select: jr > jump > taken branch > PC+4.
// The selected target is returned word-aligned; misalign_raw flags dropped low bits.
module pc_target_mux
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_off,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] next_pc,
  output pc_sel_t          sel,
  output logic             misalign_raw
);

  logic [WIDTH-1:0] target;

  always_comb begin
    pc_plus4 = pc + WIDTH'(4);
    sel      = SEL_PC4;
    target   = pc_plus4;
    if (jr) begin
      sel    = SEL_JR;
      target = rs_val;
    end else if (jump) begin
      sel    = SEL_J;
      target = {pc_plus4[WIDTH-1:28], j_index, 2'b00};
    end else if (branch && zero) begin
      sel    = SEL_BR;
      target = pc_plus4 + br_off;
    end
    misalign_raw = |target[1:0];
    next_pc      = {target[WIDTH-1:2], 2'b00};
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC register, fetch FSM and instruction-memory valid/ready request.
// Optional PC_PERF_CNT_EN adds taken_cnt / stall_cnt performance counters.
//
// state | meaning
// IDLE  | single cycle after reset, no fetch request
// FETCH | request pc; advance on ready & advance
// WAIT  | memory stalled, request held stable
// HALT  | pc reached halt address, frozen until rst
module pc_update_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH            = 32,
  parameter logic [WIDTH-1:0] RESET_VEC        = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] HALT_ADDR_EN_VAL = WIDTH'(32'hFFFF_FFFC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] br_off,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  input  logic             advance,
  output logic             imem_valid,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misalign,
`ifdef PC_PERF_CNT_EN
  output logic [31:0]      taken_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output logic             halted
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_HALT  = HALT;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic             misalign_q;
  logic             misalign_raw;
  pc_sel_t          sel;
  logic             active;
  logic             at_halt;
  logic             accept;

  pc_target_mux #(.WIDTH(WIDTH)) u_mux (
    .pc           (pc_q),
    .br_off       (br_off),
    .j_index      (j_index),
    .rs_val       (rs_val),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .jr           (jr),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .sel          (sel),
    .misalign_raw (misalign_raw)
  );

  assign active  = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign at_halt = (pc_q == HALT_ADDR_EN_VAL);
  // The halt address itself is never retired; the FSM parks instead.
  assign accept  = active && !at_halt && imem_ready && advance;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (at_halt)          state_d = S_HALT;
        else if (!imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (at_halt)         state_d = S_HALT;
        else if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= next_pc;
      if (accept && misalign_raw && (sel != SEL_PC4)) misalign_q <= 1'b1;
    end
  end

`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (sel != SEL_PC4)) taken_cnt <= taken_cnt + 32'd1;
      if (state_q == S_WAIT)          stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign imem_valid = active;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign misalign   = misalign_q;
  assign halted     = (state_q == S_HALT);

endmodule
